// File: rtl/instr_mem.sv
// Byte-addressed big-endian instruction memory, registered read and write.
// Optional IMEM_ADDR_CHECK_EN: rejects misaligned/out-of-range accesses via o_addr_err.
module instr_mem #(
    parameter int MEM_SIZEB = 128,
    parameter int NB_DATA   = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en_write,
    input  logic               i_en_read,
    input  logic [NB_DATA-1:0] i_addr,
    input  logic [NB_DATA-1:0] i_data,
`ifdef IMEM_ADDR_CHECK_EN
    output logic               o_addr_err,
`endif
    output logic [NB_DATA-1:0] o_data
);

    localparam int AW = $clog2(MEM_SIZEB);

    logic [7:0]         mem_q [MEM_SIZEB];
    logic [NB_DATA-1:0] data_q;
    logic [NB_DATA-1:0] data_d;
    logic [3:0][AW-1:0] ea;
    logic               addr_bad;
    logic               wr_ok;
    logic               rd_ok;

    // Byte lanes wrap modulo the memory size.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ea[k] = i_addr[AW-1:0] + AW'(k);
        end
    end

`ifdef IMEM_ADDR_CHECK_EN
    logic err_q;
    logic err_d;

    assign addr_bad = (i_addr > NB_DATA'(MEM_SIZEB - 4))
                   || (i_addr[1:0] != 2'b00);
    assign err_d    = (i_en_write | i_en_read) & addr_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_addr_err = err_q;
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^i_addr[NB_DATA-1:AW];
    assign addr_bad       = 1'b0;
`endif

    assign wr_ok = i_en_write & ~addr_bad;
    assign rd_ok = i_en_read & ~addr_bad;

    always_comb begin
        data_d = data_q;
        if (rd_ok) begin
            data_d = {mem_q[ea[0]], mem_q[ea[1]],
                      mem_q[ea[2]], mem_q[ea[3]]};
        end
    end

    // Read samples mem_q before this edge's write lands: read-before-write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q <= '0;
            for (int i = 0; i < MEM_SIZEB; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            data_q <= data_d;
            if (wr_ok) begin
                mem_q[ea[0]] <= i_data[31:24];
                mem_q[ea[1]] <= i_data[23:16];
                mem_q[ea[2]] <= i_data[15:8];
                mem_q[ea[3]] <= i_data[7:0];
            end
        end
    end

    assign o_data = data_q;

endmodule

// File: tb/tb_instr_mem.sv
// Directed self-checking bench for instr_mem.
// Expectations follow IMEM_ADDR_CHECK_EN when it is defined.
module tb_instr_mem;

    logic        clk;
    logic        rst_n;
    logic        en_write;
    logic        en_read;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
`ifdef IMEM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    int total;
    int bad;

    instr_mem #(.MEM_SIZEB(128), .NB_DATA(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en_write (en_write),
        .i_en_read  (en_read),
        .i_addr     (addr),
        .i_data     (wdata),
`ifdef IMEM_ADDR_CHECK_EN
        .o_addr_err (addr_err),
`endif
        .o_data     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d);
        en_write = we;
        en_read  = re;
        addr     = a;
        wdata    = d;
        @(posedge clk);
        #1;
        en_write = 1'b0;
        en_read  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        en_write = 1'b0;
        en_read = 1'b0;
        addr = '0;
        wdata = '0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_odata got=%h want=%h", rdata, 32'h0);
        end
`ifdef IMEM_ADDR_CHECK_EN
        total++;
        if (addr_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b want=0", addr_err);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc(1'b0, 1'b1, 32'd64, 32'h0);
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mem64 got=%h want=%h", rdata, 32'h0);
        end
    endtask

    task automatic test_write_read();
        cyc(1'b1, 1'b0, 32'd0, 32'h0000000A);
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL wr_no_read got=%h want=%h", rdata, 32'h0);
        end
        cyc(1'b0, 1'b1, 32'd0, 32'h0);
        total++;
        if (rdata !== 32'h0000000A) begin
            bad++;
            $display("FAIL rd0 got=%h want=%h", rdata, 32'h0000000A);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] exp;
        cyc(1'b1, 1'b0, 32'd4, 32'h11223344);
        cyc(1'b0, 1'b1, 32'd4, 32'h0);
        total++;
        if (rdata !== 32'h11223344) begin
            bad++;
            $display("FAIL rd4 got=%h want=%h", rdata, 32'h11223344);
        end
        cyc(1'b0, 1'b1, 32'd5, 32'h0);
`ifdef IMEM_ADDR_CHECK_EN
        exp = 32'h11223344;
        total++;
        if (addr_err !== 1'b1) begin
            bad++;
            $display("FAIL rd5_err got=%b want=1", addr_err);
        end
`else
        exp = 32'h22334400;
`endif
        total++;
        if (rdata !== exp) begin
            bad++;
            $display("FAIL rd5 got=%h want=%h", rdata, exp);
        end
        cyc(1'b0, 1'b1, 32'd0, 32'h0);
        cyc(1'b0, 1'b1, 32'h104, 32'h0);
`ifdef IMEM_ADDR_CHECK_EN
        exp = 32'h0000000A;
`else
        exp = 32'h11223344;
`endif
        total++;
        if (rdata !== exp) begin
            bad++;
            $display("FAIL rd_hi_bits got=%h want=%h", rdata, exp);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        cyc(1'b1, 1'b0, 32'd124, 32'hDEADBEEF);
        cyc(1'b0, 1'b1, 32'd124, 32'h0);
        total++;
        if (rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL rd124 got=%h want=%h", rdata, 32'hDEADBEEF);
        end
        cyc(1'b0, 1'b1, 32'd126, 32'h0);
`ifdef IMEM_ADDR_CHECK_EN
        exp = 32'hDEADBEEF;
        total++;
        if (addr_err !== 1'b1) begin
            bad++;
            $display("FAIL rd126_err got=%b want=1", addr_err);
        end
`else
        exp = 32'hBEEF0000;
`endif
        total++;
        if (rdata !== exp) begin
            bad++;
            $display("FAIL rd126 got=%h want=%h", rdata, exp);
        end
        cyc(1'b1, 1'b0, 32'd126, 32'h01020304);
`ifdef IMEM_ADDR_CHECK_EN
        total++;
        if (addr_err !== 1'b1) begin
            bad++;
            $display("FAIL wr126_err got=%b want=1", addr_err);
        end
        exp = 32'h0000000A;
`else
        exp = 32'h0304000A;
`endif
        cyc(1'b0, 1'b1, 32'd0, 32'h0);
`ifdef IMEM_ADDR_CHECK_EN
        total++;
        if (addr_err !== 1'b0) begin
            bad++;
            $display("FAIL rd0_err got=%b want=0", addr_err);
        end
`endif
        total++;
        if (rdata !== exp) begin
            bad++;
            $display("FAIL wrap_wr got=%h want=%h", rdata, exp);
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b1, 32'd8, 32'hCAFEF00D);
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL rbw8 got=%h want=%h", rdata, 32'h0);
        end
        cyc(1'b0, 1'b1, 32'd8, 32'h0);
        total++;
        if (rdata !== 32'hCAFEF00D) begin
            bad++;
            $display("FAIL rd8 got=%h want=%h", rdata, 32'hCAFEF00D);
        end
`ifndef IMEM_ADDR_CHECK_EN
        cyc(1'b1, 1'b1, 32'd10, 32'h55667788);
        total++;
        if (rdata !== 32'hF00D0000) begin
            bad++;
            $display("FAIL rbw10 got=%h want=%h", rdata, 32'hF00D0000);
        end
        cyc(1'b0, 1'b1, 32'd12, 32'h0);
        total++;
        if (rdata !== 32'h77880000) begin
            bad++;
            $display("FAIL rd12 got=%h want=%h", rdata, 32'h77880000);
        end
`endif
    endtask

    task automatic test_async_reset();
        cyc(1'b1, 1'b0, 32'd0, 32'h99887766);
        cyc(1'b0, 1'b1, 32'd0, 32'h0);
        total++;
        if (rdata !== 32'h99887766) begin
            bad++;
            $display("FAIL pre_rst got=%h want=%h", rdata, 32'h99887766);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL async_rst got=%h want=%h", rdata, 32'h0);
        end
        en_read = 1'b1;
        en_write = 1'b1;
        wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_dom got=%h want=%h", rdata, 32'h0);
        end
        en_read = 1'b0;
        en_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 32'd0, 32'h0);
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL post_rst0 got=%h want=%h", rdata, 32'h0);
        end
        cyc(1'b0, 1'b1, 32'd8, 32'h0);
        total++;
        if (rdata !== 32'h0) begin
            bad++;
            $display("FAIL post_rst8 got=%h want=%h", rdata, 32'h0);
        end
    endtask

    task automatic test_hold();
        cyc(1'b1, 1'b0, 32'd16, 32'h12345678);
        cyc(1'b0, 1'b1, 32'd16, 32'h0);
        total++;
        if (rdata !== 32'h12345678) begin
            bad++;
            $display("FAIL rd16 got=%h want=%h", rdata, 32'h12345678);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 32'(i * 4), 32'h0);
            total++;
            if (rdata !== 32'h12345678) begin
                bad++;
                $display("FAIL hold%0d got=%h want=%h", i, rdata,
                         32'h12345678);
            end
        end
        cyc(1'b1, 1'b0, 32'd20, 32'hA5A5A5A5);
        total++;
        if (rdata !== 32'h12345678) begin
            bad++;
            $display("FAIL hold_wr got=%h want=%h", rdata, 32'h12345678);
        end
        cyc(1'b0, 1'b1, 32'd20, 32'h0);
        total++;
        if (rdata !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL rd20 got=%h want=%h", rdata, 32'hA5A5A5A5);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_write_read();
        test_misaligned();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
